// File: rtl/bsg_wormhole_concentrator_in_stamped_pkg.sv
// Shared types and helpers for the stamped wormhole concentrator.
package bsg_wormhole_concentrator_in_stamped_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Width of an index into n items; never zero so single-input builds still have a port.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_wormhole_concentrator_in_stamped_if.sv
// Input links, concentrated output link and grant status of the concentrator.
interface bsg_wormhole_concentrator_in_stamped_if
    import bsg_wormhole_concentrator_in_stamped_pkg::*;
#(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 16
);
    localparam int id_width_lp = safe_clog2(num_in_p);

    logic [num_in_p-1:0]              links_v_i;
    logic [num_in_p*flit_width_p-1:0] links_data_i;
    logic [num_in_p-1:0]              links_ready_and_rev_o;
    logic                             concentrated_link_v_o;
    logic [flit_width_p-1:0]          concentrated_link_data_o;
    logic                             concentrated_link_ready_and_rev_i;
    logic [id_width_lp-1:0]           grant_id_o;
    logic                             locked_o;

    modport slave (
        input  links_v_i, links_data_i, concentrated_link_ready_and_rev_i,
        output links_ready_and_rev_o, concentrated_link_v_o, concentrated_link_data_o,
        output grant_id_o, locked_o
    );

    modport master (
        output links_v_i, links_data_i, concentrated_link_ready_and_rev_i,
        input  links_ready_and_rev_o, concentrated_link_v_o, concentrated_link_data_o,
        input  grant_id_o, locked_o
    );

endinterface

// File: rtl/bsg_wormhole_concentrator_in_stamped_arb.sv
// Packet-granular round-robin arbiter: rr pointer, lock FSM, body-flit counter, one-hot grant.
module bsg_wormhole_concentrator_in_stamped_arb
    import bsg_wormhole_concentrator_in_stamped_pkg::*;
#(
    parameter int num_in_p        = 2,
    parameter int len_width_p     = 3,
    parameter int hold_on_valid_p = 1,
    parameter int id_width_lp     = safe_clog2(num_in_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_in_p-1:0]             fifo_v,
    input  logic [num_in_p*len_width_p-1:0] head_len,
    input  logic                            ready_and,
    output logic                            out_v,
    output logic [id_width_lp-1:0]          grant_id,
    output logic [num_in_p-1:0]             grant_oh,
    output logic [num_in_p-1:0]             yumi,
    output logic                            locked,
    output logic                            is_header
);

    lock_state_e            state_reg, state_next;
    logic [id_width_lp-1:0] rr_ptr_reg, rr_ptr_next;
    logic [id_width_lp-1:0] grant_id_reg, grant_id_next;
    logic [len_width_p-1:0] remaining_reg, remaining_next;
    logic                   held_reg, held_next;
    logic [id_width_lp-1:0] pick;
    logic                   any_v;
    logic [len_width_p-1:0] pick_len;

    function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] id);
        return (id == id_width_lp'(num_in_p - 1)) ? '0 : id + id_width_lp'(1);
    endfunction

    // Scan downward so the lowest offset from the rr pointer is the one that sticks.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = rr_ptr_reg;
        any_v = 1'b0;
        for (int i = num_in_p - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= num_in_p) idx = idx - num_in_p;
            if (fifo_v[idx]) begin
                pick  = id_width_lp'(idx);
                any_v = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        remaining_next = remaining_reg;
        held_next      = 1'b0;
        grant_id       = grant_id_reg;
        out_v          = 1'b0;
        pick_len       = '0;
        if (state_reg == LOCKED) begin
            out_v = fifo_v[grant_id_reg];
            if (out_v && ready_and) begin
                remaining_next = remaining_reg - len_width_p'(1);
                if (remaining_reg == len_width_p'(1)) state_next = UNLOCKED;
            end
        end else begin
            if (held_reg) begin
                out_v = fifo_v[grant_id_reg];
            end else begin
                grant_id = pick;
                out_v    = any_v;
            end
            if (out_v) begin
                grant_id_next = grant_id;
                pick_len      = head_len[int'(grant_id)*len_width_p +: len_width_p];
                if (ready_and) begin
                    rr_ptr_next = next_id(grant_id);
                    if (pick_len != '0) begin
                        state_next     = LOCKED;
                        remaining_next = pick_len;
                    end
                end else begin
                    held_next = (hold_on_valid_p != 0);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg     <= UNLOCKED;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            remaining_reg <= '0;
            held_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            remaining_reg <= remaining_next;
            held_reg      <= held_next;
        end
    end

    always_comb begin
        grant_oh           = '0;
        grant_oh[grant_id] = 1'b1;
    end

    assign yumi      = grant_oh & {num_in_p{out_v & ready_and}};
    assign locked    = (state_reg == LOCKED);
    assign is_header = (state_reg == UNLOCKED);

endmodule

// File: rtl/bsg_wormhole_concentrator_in_stamped.sv
// Concentrates num_in_p buffered wormhole links onto one, whole packets at a time, optional cid stamp.
module bsg_wormhole_concentrator_in_stamped
    import bsg_wormhole_concentrator_in_stamped_pkg::*;
#(
    parameter int flit_width_p    = 16,
    parameter int len_width_p     = 3,
    parameter int cid_width_p     = 2,
    parameter int cord_width_p    = 4,
    parameter int num_in_p        = 2,
    parameter int fifo_els_p      = 2,
    parameter int stamp_cid_p     = 0,
    parameter int hold_on_valid_p = 1
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_wormhole_concentrator_in_stamped_if.slave link
);

    localparam int id_width_lp  = safe_clog2(num_in_p);
    localparam int ptr_width_lp = safe_clog2(fifo_els_p);
    localparam int cnt_width_lp = $clog2(fifo_els_p + 1);
    localparam int cid_lsb_lp   = cord_width_p + len_width_p;

    logic [num_in_p-1:0]             fifo_v, ready_vec, yumi, grant_oh;
    logic [flit_width_p-1:0]         head_data [num_in_p];
    logic [num_in_p*len_width_p-1:0] head_len;
    logic [id_width_lp-1:0]          grant_id;
    logic                            out_v, locked, is_header;
    logic [flit_width_p-1:0]         mux_data, stamped;

    genvar gi;
    for (gi = 0; gi < num_in_p; gi++) begin : g_in
        logic [flit_width_p-1:0] mem_reg [fifo_els_p];
        logic [ptr_width_lp-1:0] rptr_reg, wptr_reg;
        logic [cnt_width_lp-1:0] count_reg;
        logic                    full, enq, deq;

        // Ready is taken from occupancy before any same-cycle dequeue.
        assign full          = (count_reg == cnt_width_lp'(fifo_els_p));
        assign ready_vec[gi] = ~full & reset_n_i;
        assign enq           = link.links_v_i[gi] & ready_vec[gi];
        assign deq           = yumi[gi];

        always_ff @(posedge clk_i) begin
            if (enq) mem_reg[wptr_reg] <= link.links_data_i[gi*flit_width_p +: flit_width_p];
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rptr_reg  <= '0;
                wptr_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (enq) wptr_reg <= (wptr_reg == ptr_width_lp'(fifo_els_p - 1)) ? '0
                                     : wptr_reg + ptr_width_lp'(1);
                if (deq) rptr_reg <= (rptr_reg == ptr_width_lp'(fifo_els_p - 1)) ? '0
                                     : rptr_reg + ptr_width_lp'(1);
                count_reg <= count_reg + cnt_width_lp'(enq) - cnt_width_lp'(deq);
            end
        end

        assign fifo_v[gi]    = (count_reg != '0);
        assign head_data[gi] = mem_reg[rptr_reg];
        assign head_len[gi*len_width_p +: len_width_p] = head_data[gi][cord_width_p +: len_width_p];
    end

    bsg_wormhole_concentrator_in_stamped_arb #(
        .num_in_p        (num_in_p),
        .len_width_p     (len_width_p),
        .hold_on_valid_p (hold_on_valid_p)
    ) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .fifo_v    (fifo_v),
        .head_len  (head_len),
        .ready_and (link.concentrated_link_ready_and_rev_i),
        .out_v     (out_v),
        .grant_id  (grant_id),
        .grant_oh  (grant_oh),
        .yumi      (yumi),
        .locked    (locked),
        .is_header (is_header)
    );

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < num_in_p; i++) begin
            mux_data = mux_data | (head_data[i] & {flit_width_p{grant_oh[i]}});
        end
    end

    if (stamp_cid_p != 0 && cid_width_p > 0) begin : g_stamp
        logic [cid_width_p-1:0] cid_stamp;
        always_comb begin
            cid_stamp                   = '0;
            cid_stamp[id_width_lp-1:0]  = grant_id;
            stamped                     = mux_data;
            if (is_header) stamped[cid_lsb_lp +: cid_width_p] = cid_stamp;
        end
    end else begin : g_pass
        assign stamped = mux_data;
    end

    // Data is forced to zero when idle so nothing stale leaks out, including during reset.
    assign link.links_ready_and_rev_o    = ready_vec;
    assign link.concentrated_link_v_o    = out_v;
    assign link.concentrated_link_data_o = out_v ? stamped : '0;
    assign link.grant_id_o               = grant_id;
    assign link.locked_o                 = locked;

endmodule

// File: tb/tb_bsg_wormhole_concentrator_in_stamped.sv
// Directed and randomized packet traffic checked against a packet-level reference model.
module tb_bsg_wormhole_concentrator_in_stamped;

    localparam int FW  = 16;
    localparam int NI  = 4;
    localparam int ELS = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_wormhole_concentrator_in_stamped_if #(.num_in_p(NI), .flit_width_p(FW)) bus ();

    bsg_wormhole_concentrator_in_stamped #(
        .flit_width_p(FW), .len_width_p(3), .cid_width_p(2), .cord_width_p(4),
        .num_in_p(NI), .fifo_els_p(ELS), .stamp_cid_p(1), .hold_on_valid_p(1)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .link      (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // Model state: FIFO contents, packets waiting to be offered, and the output-side packet rules.
    logic [FW-1:0] q    [NI][$];
    logic [FW-1:0] pend [NI][$];
    bit            m_locked, m_held, m_v;
    int            m_owner, m_rem, m_last, m_held_pick, m_pick;
    logic [FW-1:0] m_data;

    logic [NI-1:0] drv_v;
    logic [FW-1:0] drv_data [NI];
    logic          drv_ready;
    bit            rand_fill;

    logic          s_v, s_locked;
    logic [NI-1:0] s_ready;
    logic [1:0]    s_grant;
    logic [FW-1:0] s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [FW-1:0] mk_hdr(input int cord, input int len, input int cid);
        logic [3:0] c4;
        logic [2:0] l3;
        logic [1:0] i2;
        logic [6:0] p7;
        c4 = 4'(cord);
        l3 = 3'(len);
        i2 = 2'(cid);
        p7 = 7'($urandom_range(127));
        return {p7, i2, l3, c4};
    endfunction

    task automatic push_pkt(input int i, input int len, input int cid);
        pend[i].push_back(mk_hdr($urandom_range(15), len, cid));
        for (int b = 0; b < len; b++) pend[i].push_back(FW'($urandom));
    endtask

    task automatic reset_model();
        m_locked = 0; m_held = 0; m_v = 0;
        m_owner = 0; m_rem = 0; m_last = NI - 1; m_held_pick = 0; m_pick = 0;
        for (int i = 0; i < NI; i++) begin
            q[i].delete();
            pend[i].delete();
        end
    endtask

    task automatic drive(input int pv);
        for (int i = 0; i < NI; i++) begin
            if (rand_fill && pend[i].size() == 0)
                push_pkt(i, ($urandom_range(9) == 0) ? 7 : $urandom_range(3), $urandom_range(3));
            drv_v[i]    = (pend[i].size() != 0) && ($urandom_range(99) < pv);
            drv_data[i] = (pend[i].size() != 0) ? pend[i][0] : FW'($urandom);
            bus.links_data_i[i*FW +: FW] = drv_data[i];
        end
        bus.links_v_i = drv_v;
        bus.concentrated_link_ready_and_rev_i = drv_ready;
    endtask

    // Apply the clock edge that just passed to the model, then predict and check the outputs.
    task automatic step();
        bit            acc [NI];
        logic [FW-1:0] flit;
        logic [NI-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < NI; i++) acc[i] = drv_v[i] && (q[i].size() < ELS);
        if (m_v && drv_ready) begin
            flit = q[m_pick].pop_front();
            if (!m_locked) begin
                m_last = m_pick;
                if (flit[6:4] != 3'd0) begin
                    m_locked = 1; m_owner = m_pick; m_rem = int'(flit[6:4]);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_locked = 0;
            end
            m_held = 0;
        end else begin
            m_held = m_v && !m_locked;
            m_held_pick = m_pick;
        end
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) begin
                q[i].push_back(drv_data[i]);
                void'(pend[i].pop_front());
            end
        end
        m_v = 0;
        if (m_locked) begin
            m_pick = m_owner;
            m_v = (q[m_owner].size() != 0);
        end else if (m_held) begin
            m_pick = m_held_pick;
            m_v = 1;
        end else begin
            for (int k = 1; k <= NI; k++) begin
                int c;
                c = (m_last + k) % NI;
                if (!m_v && q[c].size() != 0) begin
                    m_v = 1; m_pick = c;
                end
            end
        end
        if (m_v) begin
            m_data = q[m_pick][0];
            if (!m_locked) m_data[8:7] = 2'(m_pick);
        end
        for (int i = 0; i < NI; i++) exp_rdy[i] = (q[i].size() < ELS);
        s_v      = bus.concentrated_link_v_o;
        s_locked = bus.locked_o;
        s_ready  = bus.links_ready_and_rev_o;
        s_grant  = bus.grant_id_o;
        s_data   = bus.concentrated_link_data_o;
        check("ready", 32'(s_ready), 32'(exp_rdy));
        check("v", 32'(s_v), 32'(m_v));
        check("locked", 32'(s_locked), 32'(m_locked));
        if (m_v) begin
            check("grant", 32'(s_grant), 32'(m_pick));
            check("data", 32'(s_data), 32'(m_data));
        end
    endtask

    task automatic drain();
        bit busy;
        rand_fill = 0;
        drv_ready = 1'b1;
        busy = 1;
        for (int n = 0; n < 300 && busy; n++) begin
            drive(100);
            step();
            busy = m_locked;
            for (int i = 0; i < NI; i++) if (q[i].size() != 0 || pend[i].size() != 0) busy = 1;
        end
        check("drain_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.links_ready_and_rev_o), 32'd0);
        check({tag, "_v"}, 32'(bus.concentrated_link_v_o), 32'd0);
        check({tag, "_data"}, 32'(bus.concentrated_link_data_o), 32'd0);
        check({tag, "_grant"}, 32'(bus.grant_id_o), 32'd0);
        check({tag, "_locked"}, 32'(bus.locked_o), 32'd0);
    endtask

    initial begin
        logic [FW-1:0] held_data;
        logic [1:0]    held_grant;
        int            locked_cycles;
        bit            seen;

        reset_model();
        rand_fill = 0;
        drv_v = '0;
        drv_ready = 1'b1;
        for (int i = 0; i < NI; i++) drv_data[i] = '0;
        bus.links_v_i = '0;
        bus.links_data_i = '0;
        bus.concentrated_link_ready_and_rev_i = 1'b1;
        #3 check_reset_outputs("por");
        #9 reset_n = 1'b1;
        step();

        // Four len=2 packets offered together leave in input order, back to back.
        for (int i = 0; i < NI; i++) push_pkt(i, 2, 0);
        for (int k = 0; k < 12; k++) begin
            drive(100);
            step();
            check("t1_v", 32'(s_v), 32'd1);
            check("t1_grant", 32'(s_grant), 32'(k / 3));
        end
        drain();

        // Single-flit packets from inputs 0 and 3 alternate with no bubbles.
        for (int n = 0; n < 6; n++) begin
            push_pkt(0, 0, 1);
            push_pkt(3, 0, 2);
        end
        for (int k = 0; k < 8; k++) begin
            drive(100);
            step();
            check("t5_v", 32'(s_v), 32'd1);
            check("t5_locked", 32'(s_locked), 32'd0);
            check("t5_grant", 32'(s_grant), (k % 2 == 0) ? 32'd0 : 32'd3);
        end
        drain();

        // Stalled output holds pick and data while another input becomes valid; input 1 fills up.
        drv_ready = 1'b0;
        push_pkt(1, 4, 0);
        held_data = '0;
        held_grant = '0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) push_pkt(2, 0, 0);
            drive(100);
            step();
            if (k == 0) begin
                held_data = s_data;
                held_grant = s_grant;
                check("t4_grant0", 32'(s_grant), 32'd1);
            end else begin
                check("t4_data_hold", 32'(s_data), 32'(held_data));
                check("t4_grant_hold", 32'(s_grant), 32'(held_grant));
            end
            if (k == 4) check("t4_full", 32'(s_ready[1]), 32'd0);
        end
        drain();

        // cid stamping on a two-flit packet from input 2.
        push_pkt(2, 1, 0);
        locked_cycles = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            drive(100);
            step();
            if (s_locked) locked_cycles++;
            if (s_v && !seen) begin
                seen = 1;
                check("t2_grant", 32'(s_grant), 32'd2);
                check("t2_cid", 32'(s_data[8:7]), 32'd2);
            end
        end
        check("t2_locked_cycles", 32'(locked_cycles), 32'd1);
        drain();

        // Randomized traffic with random back-pressure.
        rand_fill = 1;
        for (int n = 0; n < 600; n++) begin
            drv_ready = ($urandom_range(3) != 0);
            drive(70);
            step();
        end
        drain();

        // Asynchronous reset in the middle of a packet.
        push_pkt(0, 5, 0);
        for (int k = 0; k < 4; k++) begin
            drive(100);
            step();
        end
        check("t6_locked_pre", 32'(s_locked), 32'd1);
        #3 reset_n = 1'b0;
        drv_v = '0;
        bus.links_v_i = '0;
        #1 check_reset_outputs("t6_rst");
        reset_model();
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        rand_fill = 1;
        for (int n = 0; n < 300; n++) begin
            drv_ready = ($urandom_range(3) != 0);
            drive(70);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
